// File: rtl/ant_nav_ctrl.sv
// rtl/ant_nav_ctrl.sv - right-hand wall-following navigation controller for one maze ant
module ant_nav_ctrl #(
  parameter int START_HALTS = 2,
  parameter int MAX_TURNS   = 4,
  parameter int PH_W        = 2,
  parameter int STEP_W      = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic              ant_r,
  input  logic              ant_l,
  input  logic              hit,
  input  logic              escape,
  input  logic [PH_W-1:0]   ph_detected,
  output logic [1:0]        move,
  output logic [PH_W-1:0]   ph_drop,
  output logic [STEP_W-1:0] steps,
  output logic              done,
  output logic              stuck
);

  localparam logic [1:0] HALT    = 2'b00;
  localparam logic [1:0] RIGHT   = 2'b01;
  localparam logic [1:0] LEFT    = 2'b10;
  localparam logic [1:0] FORWARD = 2'b11;

  localparam int SC_W = $clog2(START_HALTS + 1);
  localparam int TC_W = $clog2(MAX_TURNS + 1);

  typedef enum logic [2:0] {
    S_START,
    S_SEEK,
    S_FOLLOW,
    S_POST_R,
    S_DONE,
    S_STUCK
  } state_t;

  state_t            state_q, state_d, want_state;
  logic [SC_W-1:0]   start_q, start_d;
  logic [TC_W-1:0]   turn_q, turn_d;
  logic [1:0]        want, move_d;
  logic              want_valid;
  logic [PH_W-1:0]   ph_drop_d;

  // The left feeler is reported by the environment but plays no part in the right-hand rule.
  logic unused_ant_l;
  assign unused_ant_l = ant_l;

  // Pick the wall-following move, then veto it into STUCK on the turn limit or a saturated cell.
  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    turn_d     = turn_q;
    move_d     = HALT;
    ph_drop_d  = '0;
    want       = HALT;
    want_state = state_q;
    want_valid = 1'b0;
    if (go) begin
      case (state_q)
        S_START: begin
          if (start_q == SC_W'(START_HALTS - 1)) begin
            state_d = S_SEEK;
            start_d = '0;
          end else begin
            start_d = start_q + SC_W'(1);
          end
        end
        S_SEEK: begin
          if (escape) begin
            state_d = S_DONE;
          end else begin
            want_valid = 1'b1;
            if (hit) begin
              want       = LEFT;
              want_state = S_FOLLOW;
            end else if (ant_r) begin
              want       = FORWARD;
              want_state = S_FOLLOW;
            end else begin
              want       = FORWARD;
            end
          end
        end
        S_FOLLOW: begin
          if (escape) begin
            state_d = S_DONE;
          end else begin
            want_valid = 1'b1;
            if (hit) begin
              want = LEFT;
            end else if (!ant_r) begin
              want       = RIGHT;
              want_state = S_POST_R;
            end else begin
              want = FORWARD;
            end
          end
        end
        S_POST_R: begin
          if (escape) begin
            state_d = S_DONE;
          end else begin
            want_valid = 1'b1;
            want_state = S_FOLLOW;
            want       = hit ? LEFT : FORWARD;
          end
        end
        default: ;
      endcase

      if (want_valid) begin
        if (want == FORWARD) begin
          if (ph_detected == '1) begin
            state_d = S_STUCK;
          end else begin
            move_d    = FORWARD;
            ph_drop_d = ph_detected + PH_W'(1);
            turn_d    = '0;
            state_d   = want_state;
          end
        end else begin
          if (turn_q == TC_W'(MAX_TURNS - 1)) begin
            state_d = S_STUCK;
          end else begin
            move_d  = want;
            turn_d  = turn_q + TC_W'(1);
            state_d = want_state;
          end
        end
      end
    end
  end

  // Register state, counters and every output so the move is stable for a whole cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_START;
      start_q <= '0;
      turn_q  <= '0;
      move    <= HALT;
      ph_drop <= '0;
      steps   <= '0;
      done    <= 1'b0;
      stuck   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      turn_q  <= turn_d;
      move    <= move_d;
      ph_drop <= ph_drop_d;
      if (move_d == FORWARD && steps != '1) begin
        steps <= steps + STEP_W'(1);
      end
      done    <= (state_d == S_DONE);
      stuck   <= (state_d == S_STUCK);
    end
  end

endmodule

// File: tb/tb_ant_nav_ctrl.sv
// tb/tb_ant_nav_ctrl.sv - randomized self-checking bench for ant_nav_ctrl against a behavioural model
module tb_ant_nav_ctrl;

  localparam int START_HALTS = 2;
  localparam int MAX_TURNS   = 4;
  localparam int PH_W        = 2;
  localparam int STEP_W      = 10;
  localparam int STEP_MAX    = (1 << STEP_W) - 1;
  localparam int PH_MAX      = (1 << PH_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              go = 1'b0;
  logic              ant_r = 1'b0;
  logic              ant_l = 1'b0;
  logic              hit = 1'b0;
  logic              escape = 1'b0;
  logic [PH_W-1:0]   ph_detected = '0;
  logic [1:0]        move;
  logic [PH_W-1:0]   ph_drop;
  logic [STEP_W-1:0] steps;
  logic              done;
  logic              stuck;

  int n_checks = 0;
  int n_fail   = 0;

  ant_nav_ctrl #(
    .START_HALTS(START_HALTS),
    .MAX_TURNS(MAX_TURNS),
    .PH_W(PH_W),
    .STEP_W(STEP_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .go(go),
    .ant_r(ant_r),
    .ant_l(ant_l),
    .hit(hit),
    .escape(escape),
    .ph_detected(ph_detected),
    .move(move),
    .ph_drop(ph_drop),
    .steps(steps),
    .done(done),
    .stuck(stuck)
  );

  always #5 clk = ~clk;

  // Behavioural model: halts still owed, whether a wall has been found, whether the last move was a right turn.
  int halts_left  = START_HALTS;
  int on_wall     = 0;
  int after_right = 0;
  int turns       = 0;
  int m_steps     = 0;
  int m_done      = 0;
  int m_stuck     = 0;
  int e_move      = 0;
  int e_ph        = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    halts_left = START_HALTS; on_wall = 0; after_right = 0; turns = 0;
    m_steps = 0; m_done = 0; m_stuck = 0; e_move = 0; e_ph = 0;
  endtask

  task automatic model_tick();
    int want;
    e_move = 0;
    e_ph   = 0;
    if (!go || m_done != 0 || m_stuck != 0) return;
    if (halts_left > 0) begin
      halts_left--;
      return;
    end
    if (escape) begin
      m_done = 1;
      return;
    end
    // Right-hand rule: wall ahead -> left; lost the right wall (not just after turning) -> right; else forward.
    if (hit) want = 2;
    else if (on_wall != 0 && after_right == 0 && !ant_r) want = 1;
    else want = 3;
    after_right = 0;
    if (want == 3) begin
      if (int'(ph_detected) == PH_MAX) begin
        m_stuck = 1;
        return;
      end
      e_move = 3;
      e_ph   = int'(ph_detected) + 1;
      turns  = 0;
      if (m_steps < STEP_MAX) m_steps++;
    end else begin
      if (turns + 1 >= MAX_TURNS) begin
        m_stuck = 1;
        return;
      end
      e_move      = want;
      turns       = turns + 1;
      after_right = (want == 1) ? 1 : 0;
    end
    if (hit || ant_r) on_wall = 1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_tick();
  end

  always @(negedge clk) begin
    check("move", 32'(move), e_move);
    check("ph_drop", 32'(ph_drop), e_ph);
    check("steps", 32'(steps), m_steps);
    check("done", 32'(done), m_done);
    check("stuck", 32'(stuck), m_stuck);
  end

  task automatic set_in(input logic g, input logic r, input logic h, input logic e, input int ph);
    go = g; ant_r = r; hit = h; escape = e;
    ant_l = 1'($urandom_range(0, 1));
    ph_detected = ph[PH_W-1:0];
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(1, 0, 0, 0, 0);
    cyc();
    cyc();
    check("rst_move", 32'(move), 0);
    check("rst_steps", 32'(steps), 0);
    check("rst_flags", 32'({done, stuck}), 0);
    rst_n = 1'b1;
  endtask

  task automatic lit(input string name, input int mv, input int st, input int dn, input int sk);
    check({name, "_move"}, 32'(move), mv);
    check({name, "_steps"}, 32'(steps), st);
    check({name, "_done"}, 32'(done), dn);
    check({name, "_stuck"}, 32'(stuck), sk);
  endtask

  initial begin
    cyc();
    // startup halts, seek, follow, right turn, post-right hit, turn limit
    do_reset();
    cyc(); lit("start1", 0, 0, 0, 0);
    cyc(); lit("start2", 0, 0, 0, 0);
    cyc(); lit("seek1", 3, 1, 0, 0);
    cyc(); lit("seek2", 3, 2, 0, 0);
    cyc(); lit("seek3", 3, 3, 0, 0);
    set_in(1, 1, 0, 0, 0); cyc(); lit("to_follow", 3, 4, 0, 0);
    set_in(1, 0, 0, 0, 0); cyc(); lit("right", 1, 4, 0, 0);
    set_in(1, 0, 1, 0, 0); cyc(); lit("post_r_hit", 2, 4, 0, 0);
    set_in(1, 1, 0, 0, 0); cyc(); lit("follow_fwd", 3, 5, 0, 0);
    set_in(1, 1, 1, 0, 0);
    cyc(); lit("left1", 2, 5, 0, 0);
    cyc(); lit("left2", 2, 5, 0, 0);
    cyc(); lit("left3", 2, 5, 0, 0);
    cyc(); lit("turn_limit", 0, 5, 0, 1);
    set_in(1, 0, 0, 0, 0);
    repeat (3) cyc();
    lit("stuck_hold", 0, 5, 0, 1);

    // pheromone marking and loop detection
    do_reset();
    cyc(); cyc();
    set_in(1, 0, 0, 0, 0); cyc(); check("ph0", 32'(ph_drop), 1);
    set_in(1, 0, 0, 0, 1); cyc(); check("ph1", 32'(ph_drop), 2);
    set_in(1, 0, 0, 0, 3); cyc(); check("ph3_drop", 32'(ph_drop), 0);
    lit("loop", 0, 2, 0, 1);

    // escape beats hit in FOLLOW, then absorbing, then async reset
    do_reset();
    cyc(); cyc();
    set_in(1, 1, 0, 0, 0); cyc();
    set_in(1, 1, 1, 1, 0); cyc(); lit("escape", 0, 1, 1, 0);
    repeat (4) begin
      set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
             int'($urandom_range(0, 3)));
      cyc();
    end
    lit("done_hold", 0, 1, 1, 0);
    rst_n = 1'b0;
    #1;
    lit("async_rst", 0, 0, 0, 0);
    cyc();

    // escape beats a pending loop trigger
    do_reset();
    cyc(); cyc();
    set_in(1, 0, 0, 1, 3); cyc(); lit("esc_loop", 0, 0, 1, 0);

    // go low freezes state, steps and turn count
    do_reset();
    cyc(); cyc();
    set_in(1, 1, 0, 0, 0); cyc();
    set_in(1, 1, 1, 0, 0); cyc(); lit("g_left1", 2, 1, 0, 0);
    set_in(0, 1, 1, 0, 0);
    repeat (3) begin
      cyc(); lit("go_low", 0, 1, 0, 0);
    end
    set_in(1, 1, 1, 0, 0);
    cyc(); lit("g_left2", 2, 1, 0, 0);
    cyc(); lit("g_left3", 2, 1, 0, 0);
    cyc(); lit("g_limit", 0, 1, 0, 1);

    // randomized navigation rounds with occasional mid-run resets
    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int c = 0; c < 300; c++) begin
        if ($urandom_range(0, 149) == 0) rst_n = 1'b0;
        else rst_n = 1'b1;
        set_in(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 99) == 0),
               ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, 2)));
        cyc();
      end
      rst_n = 1'b1;
    end

    // long open-field run to reach step saturation
    do_reset();
    for (int c = 0; c < 1040; c++) begin
      set_in(1, 0, 0, 0, int'($urandom_range(0, 2)));
      cyc();
    end
    check("steps_sat", 32'(steps), 1023);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
